// File: rtl/noise_source_multi.sv
// noise_source_multi: shared LFSR noise, per-channel decaying bursts, lowpass filters and saturated mix (in: clk, reset, clk_3MHz_en, clk_12KHz_en, sound_enable, noise_en, loud_soft, rate_div; out: noise_out, mix_out)
module noise_source_multi #(
  parameter int NUM_CH = 2,
  parameter logic [4*NUM_CH-1:0] CUTOFF_SH = {4'd8, 4'd7},
  parameter logic [4*NUM_CH-1:0] DECAY_SH = {4'd2, 4'd7}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_3MHz_en,
  input  logic                   clk_12KHz_en,
  input  logic                   sound_enable,
  input  logic [NUM_CH-1:0]      noise_en,
  input  logic [NUM_CH-1:0]      loud_soft,
  input  logic [4*NUM_CH-1:0]    rate_div,
  output logic [16*NUM_CH-1:0]   noise_out,
  output logic [15:0]            mix_out
);
  typedef enum logic {IDLE, DECAY} state_t;
  logic [16:0] r_lfsr;
  logic        r_arm;
  logic [15:0] r_mix;
  logic [15:0] w_y [NUM_CH];
  logic [18:0] w_sum;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_lfsr <= '1;
    else if (r_lfsr == '0) r_lfsr <= '1;
    else if (sound_enable && clk_12KHz_en) r_lfsr <= {r_lfsr[15:0], r_lfsr[16] ^ r_lfsr[13]};
  always_ff @(posedge clk or posedge reset)
    if (reset) r_arm <= 1'b0;
    else r_arm <= 1'b1;
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [3:0] DSH = DECAY_SH[4*i +: 4];
      localparam logic [3:0] CSH = CUTOFF_SH[4*i +: 4];
      logic [3:0]         r_div;
      logic               r_nb;
      logic               r_ne_d;
      state_t             r_st;
      state_t             w_st_nx;
      logic [15:0]        r_env;
      logic [15:0]        w_env_nx;
      logic [15:0]        r_y;
      logic [15:0]        r_out;
      logic               w_edge;
      logic [15:0]        w_dec;
      logic [15:0]        w_raw;
      logic signed [16:0] w_diff;
      logic signed [16:0] w_step;
      assign w_edge = noise_en[i] & ~r_ne_d & r_arm;
      assign w_dec = r_env >> DSH;
      assign w_raw = r_nb ? r_env : 16'h0000;
      assign w_diff = $signed({1'b0, w_raw}) - $signed({1'b0, r_y});
      assign w_step = w_diff >>> CSH;
      assign w_y[i] = r_y;
      assign noise_out[16*i +: 16] = r_out;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_div <= '0;
          r_nb <= 1'b0;
        end else if (sound_enable && clk_12KHz_en) begin
          r_div <= (r_div == rate_div[4*i +: 4]) ? 4'd0 : r_div + 4'd1;
          r_nb <= (r_div == rate_div[4*i +: 4]) ? r_lfsr[i % 17] : r_nb;
        end
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_ne_d <= 1'b0;
          r_st <= IDLE;
          r_env <= '0;
        end else begin
          r_ne_d <= noise_en[i];
          r_st <= w_st_nx;
          r_env <= w_env_nx;
        end
      always_comb begin
        w_st_nx = r_st;
        w_env_nx = r_env;
        if (!sound_enable) begin
          w_st_nx = IDLE;
          w_env_nx = '0;
        end else if (w_edge) begin
          w_st_nx = DECAY;
          w_env_nx = loud_soft[i] ? 16'hFFFF : 16'h7FFF;
        end else if (r_st == DECAY && clk_12KHz_en) begin
          w_st_nx = (w_dec == '0) ? IDLE : DECAY;
          w_env_nx = (w_dec == '0) ? 16'h0000 : r_env - w_dec;
        end
      end
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_y <= '0;
          r_out <= '0;
        end else if (!sound_enable) begin
          r_y <= '0;
          r_out <= '0;
        end else begin
          r_y <= clk_3MHz_en ? 16'({1'b0, r_y} + w_step) : r_y;
          r_out <= r_y;
        end
    end
  endgenerate
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_CH; k++) w_sum = w_sum + {3'b000, w_y[k]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_mix <= '0;
    else if (!sound_enable) r_mix <= '0;
    else if (clk_3MHz_en) r_mix <= (|w_sum[18:16]) ? 16'hFFFF : w_sum[15:0];
  assign mix_out = r_mix;
endmodule

// File: tb/tb_noise_source_multi.sv
// tb_noise_source_multi: directed self-checking bench for noise_source_multi
module tb_noise_source_multi;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_3MHz_en = 1'b0;
  logic        clk_12KHz_en = 1'b0;
  logic        sound_enable = 1'b0;
  logic [1:0]  noise_en = '0;
  logic [1:0]  loud_soft = '0;
  logic [7:0]  rate_div = '0;
  logic [31:0] noise_out;
  logic [15:0] mix_out;
  int total = 0;
  int bad = 0;
  logic [16:0] m_lfsr;
  logic [3:0]  m_div [2];
  logic        m_nb [2];
  logic [15:0] m_env [2];
  bit          m_dec [2];
  int          y [2];
  int          dsh [2] = '{7, 2};
  int          csh [2] = '{7, 8};
  noise_source_multi dut (
    .clk(clk), .reset(reset), .clk_3MHz_en(clk_3MHz_en), .clk_12KHz_en(clk_12KHz_en),
    .sound_enable(sound_enable), .noise_en(noise_en), .loud_soft(loud_soft),
    .rate_div(rate_div), .noise_out(noise_out), .mix_out(mix_out)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model_reset();
    m_lfsr = '1;
    for (int c = 0; c < 2; c++) begin
      m_div[c] = '0;
      m_nb[c] = 1'b0;
      m_env[c] = '0;
      m_dec[c] = 1'b0;
      y[c] = 0;
    end
  endfunction
  function automatic void model_tick();
    logic [16:0] o;
    logic [15:0] d;
    o = m_lfsr;
    for (int c = 0; c < 2; c++) begin
      if (m_div[c] == rate_div[4*c +: 4]) begin
        m_div[c] = '0;
        m_nb[c] = o[c];
      end else m_div[c] = m_div[c] + 4'd1;
      if (m_dec[c]) begin
        d = m_env[c] >> dsh[c];
        if (d == 0) begin
          m_env[c] = '0;
          m_dec[c] = 1'b0;
        end else m_env[c] = m_env[c] - d;
      end
    end
    m_lfsr = (o == '0) ? '1 : {o[15:0], o[16] ^ o[13]};
  endfunction
  task automatic tick();
    model_tick();
    clk_12KHz_en = 1'b1;
    step();
    clk_12KHz_en = 1'b0;
  endtask
  task automatic trig(input int c, input bit loud);
    noise_en[c] = 1'b1;
    loud_soft[c] = loud;
    m_env[c] = loud ? 16'hFFFF : 16'h7FFF;
    m_dec[c] = 1'b1;
    step();
  endtask
  task automatic trig_tick(input int c);
    model_tick();
    m_env[c] = 16'hFFFF;
    m_dec[c] = 1'b1;
    noise_en[c] = 1'b1;
    loud_soft[c] = 1'b1;
    clk_12KHz_en = 1'b1;
    step();
    clk_12KHz_en = 1'b0;
  endtask
  task automatic drop(input int c);
    noise_en[c] = 1'b0;
    step();
  endtask
  initial begin
    int n;
    int s;
    logic [15:0] mix_exp;
    model_reset();
    repeat (3) step();
    chk("rst_noise_out", noise_out, 32'h0);
    chk("rst_mix", {16'h0, mix_out}, 32'h0);
    chk("rst_lfsr", {15'h0, dut.r_lfsr}, 32'h1FFFF);
    chk("rst_env0", {16'h0, dut.g_ch[0].r_env}, 32'h0);
    reset = 1'b0;
    sound_enable = 1'b1;
    rate_div = 8'h30;
    step();
    chk("lfsr_hold", {15'h0, dut.r_lfsr}, 32'h1FFFF);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("lfsr_seq", {15'h0, dut.r_lfsr}, {15'h0, m_lfsr});
      chk("lfsr_nonzero", {31'h0, dut.r_lfsr != '0}, 32'h1);
      chk("nb0", {31'h0, dut.g_ch[0].r_nb}, {31'h0, m_nb[0]});
      chk("nb1_div4", {31'h0, dut.g_ch[1].r_nb}, {31'h0, m_nb[1]});
    end
    trig(0, 1'b1);
    chk("ch0_load", {16'h0, dut.g_ch[0].r_env}, 32'hFFFF);
    chk("ch0_decay_st", {31'h0, dut.g_ch[0].r_st}, 32'h1);
    drop(0);
    chk("ch0_fall_keeps", {16'h0, dut.g_ch[0].r_env}, 32'hFFFF);
    tick();
    chk("ch0_first_decay", {16'h0, dut.g_ch[0].r_env}, 32'hFE00);
    n = 0;
    while (m_env[0] >= 16'h1000 && n < 2000) begin
      tick();
      chk("ch0_env", {16'h0, dut.g_ch[0].r_env}, {16'h0, m_env[0]});
      n++;
    end
    trig_tick(0);
    chk("retrig_coincident", {16'h0, dut.g_ch[0].r_env}, 32'hFFFF);
    drop(0);
    n = 0;
    while (m_dec[0] && n < 3000) begin
      tick();
      chk("ch0_env_tail", {16'h0, dut.g_ch[0].r_env}, {16'h0, m_env[0]});
      n++;
    end
    chk("ch0_idle_env", {16'h0, dut.g_ch[0].r_env}, 32'h0);
    chk("ch0_idle_st", {31'h0, dut.g_ch[0].r_st}, 32'h0);
    trig(1, 1'b0);
    chk("ch1_soft_load", {16'h0, dut.g_ch[1].r_env}, 32'h7FFF);
    drop(1);
    tick();
    chk("ch1_first_decay", {16'h0, dut.g_ch[1].r_env}, 32'h6000);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("ch1_env", {16'h0, dut.g_ch[1].r_env}, {16'h0, m_env[1]});
      chk("ch1_nb", {31'h0, dut.g_ch[1].r_nb}, {31'h0, m_nb[1]});
    end
    rate_div = 8'h00;
    n = 0;
    while (!(m_nb[0] && m_nb[1]) && n < 200) begin
      tick();
      n++;
    end
    chk("nb_both", {30'h0, dut.g_ch[1].r_nb, dut.g_ch[0].r_nb}, 32'h3);
    trig(0, 1'b1);
    trig(1, 1'b1);
    chk("both_loaded", {dut.g_ch[1].r_env, dut.g_ch[0].r_env}, 32'hFFFF_FFFF);
    for (int k = 0; k < 1500; k++) begin
      s = y[0] + y[1];
      mix_exp = (s > 65535) ? 16'hFFFF : s[15:0];
      for (int c = 0; c < 2; c++) y[c] = y[c] + ((65535 - y[c]) >>> csh[c]);
      clk_3MHz_en = 1'b1;
      step();
      clk_3MHz_en = 1'b0;
      step();
      chk("y0", {16'h0, noise_out[15:0]}, y[0]);
      chk("y1", {16'h0, noise_out[31:16]}, y[1]);
      chk("mix", {16'h0, mix_out}, {16'h0, mix_exp});
    end
    chk("mix_sat", {16'h0, mix_out}, 32'hFFFF);
    chk("y0_near_top", {31'h0, noise_out[15:0] >= 16'hFF80}, 32'h1);
    sound_enable = 1'b0;
    step();
    chk("dis_noise_out", noise_out, 32'h0);
    chk("dis_mix", {16'h0, mix_out}, 32'h0);
    chk("dis_env", {dut.g_ch[1].r_env, dut.g_ch[0].r_env}, 32'h0);
    sound_enable = 1'b1;
    step();
    step();
    chk("reen_no_burst", {dut.g_ch[1].r_env, dut.g_ch[0].r_env}, 32'h0);
    chk("reen_idle", {30'h0, dut.g_ch[1].r_st, dut.g_ch[0].r_st}, 32'h0);
    sound_enable = 1'b0;
    noise_en[0] = 1'b0;
    step();
    noise_en[0] = 1'b1;
    step();
    sound_enable = 1'b1;
    step();
    step();
    chk("dis_edge_ignored", {16'h0, dut.g_ch[0].r_env}, 32'h0);
    drop(0);
    trig(0, 1'b1);
    chk("pre_reset_load", {16'h0, dut.g_ch[0].r_env}, 32'hFFFF);
    reset = 1'b1;
    #2;
    chk("async_rst_env", {16'h0, dut.g_ch[0].r_env}, 32'h0);
    chk("async_rst_lfsr", {15'h0, dut.r_lfsr}, 32'h1FFFF);
    step();
    reset = 1'b0;
    model_reset();
    step();
    step();
    chk("post_rst_no_burst", {16'h0, dut.g_ch[0].r_env}, 32'h0);
    chk("post_rst_idle", {31'h0, dut.g_ch[0].r_st}, 32'h0);
    drop(0);
    trig(0, 1'b0);
    chk("fresh_edge", {16'h0, dut.g_ch[0].r_env}, 32'h7FFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
